dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder: the memory-side end of the `mem_in`/`mem_out` data port that the execute stage waits on through `mem_ready`. It accepts one load or store request at a time and applies byte-strobed writes to an internal word-addressed RAM. After a programmable number of wait states it returns a single-cycle `mem_ready` with `mem_rdata`. It sits between the core's data port and the bus, as a tightly-coupled data RAM.

## Interface
Parameters:
- `DEPTH`, 1024 — RAM size in 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 0 — extra cycles between request acceptance and response; range 0..15.
- `BASE`, 32'h8000_0000 — byte address of word 0; aligned to `DEPTH*4`.

Ports:
- `rst` in 1 — reset: synchronous, active-low.
- `clk` in 1 — clock.
- `mem_valid` in 1 — request strobe; sampled only when idle or responding.
- `mem_instr` in 1 — fetch tag; ignored, treated as data.
- `mem_addr` in 32 — byte address; bits [1:0] ignored, because the LSU pre-aligns addresses.
- `mem_wdata` in 32 — store data, lane-aligned.
- `mem_wstrb` in 4 — byte enables; nonzero = store, zero = load.
- `mem_ready` out 1 — one-cycle response pulse.
- `mem_rdata` out 32 — load data, valid when `mem_ready`=1.
- `mem_error` out 1 — address out of range, valid when `mem_ready`=1.

## Operation
- States: IDLE, WAIT, RESP.
- Request latch: on acceptance, `mem_addr`, `mem_wdata` and `mem_wstrb` are copied into request registers. Inputs may change afterwards.
- Range check: `off = mem_addr - BASE`; the request is in range iff `off < DEPTH*4`, computed as an unsigned 32-bit compare. Word index = `off[log2(DEPTH)+1:2]`.
- IDLE:
  - `mem_valid`=1 → accept. Go to WAIT with counter = `WAIT_STATES`, or directly to RESP if `WAIT_STATES`=0.
  - `mem_valid`=0 → stay in IDLE.
- WAIT:
  - Counter decrements each cycle; at 1 → RESP.
  - `mem_valid` is ignored; the requester must not issue while a request is outstanding.
- Entry to RESP (commit cycle), registered:
  - In-range store: RAM word updated for each lane `i` with `wstrb[i]`=1, using `wdata[8i+7:8i]`. Other lanes unchanged.
  - In-range load: `mem_rdata` = RAM word.
  - Any store: `mem_rdata` = 0.
  - Out of range: no write, `mem_rdata` = 0, `mem_error` = 1.
- RESP: `mem_ready`=1 for exactly this cycle.
  - `mem_valid`=1 → accept new request (back-to-back); next state as from IDLE.
  - Otherwise → IDLE.
- Outside RESP: `mem_ready`=0 and `mem_error`=0. `mem_rdata` holds its last value.
- Ordering: a load to the same word as the immediately preceding store returns the post-store data. The write commits before the next request reaches its commit cycle.
- RAM contents are not reset and are undefined at power-up. The simulation model initialises them to 0.

## Timing
- Reset (`rst`=0 at a rising edge):
  - State → IDLE; `mem_ready`=0, `mem_rdata`=0, `mem_error`=0; counter cleared.
  - A request in WAIT is dropped and its store is not committed.
  - A store already committed (in RESP) stays in RAM.
- Latency: request accepted at edge N → `mem_ready` high during cycle N+1+`WAIT_STATES`.
- Throughput: with `WAIT_STATES`=0 and `mem_valid` held high, one response per cycle.
- Throughput: with `WAIT_STATES`=k, one response every k+1 cycles.
- `mem_valid` during WAIT has no effect; it is neither queued nor counted.
- Address wrap: `mem_addr` < `BASE` underflows `off` to a large value → out of range. `BASE + DEPTH*4 - 4` is the last valid word.
- Strobe `4'b0000` with `mem_valid`=1 is a load.
- Non-contiguous strobes (e.g. `4'b0101`) are honoured lane by lane.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst`=0 for 3 cycles, then release with `mem_valid`=0.
  - Required: `mem_ready`=`mem_error`=0 and `mem_rdata`=0 throughout; no `mem_ready` pulse for 10 cycles.
- Store then load, `WAIT_STATES`=0:
  - Stimulus: store `0xDEADBEEF`, strobe `1111`, at `0x8000_0010`; next cycle, load `0x8000_0010`.
  - Required: ready one cycle after each request; load returns `0xDEADBEEF`; back-to-back gives a ready pulse on two consecutive cycles.
- Byte lanes:
  - Stimulus: after the above, store `0x0000_1100` with strobe `0010`, then store `0x5500_0000` with strobe `1000`, then load.
  - Required: load returns `0x55AD11EF`.
- Wait states, `WAIT_STATES`=3:
  - Stimulus: load accepted at edge N; toggle `mem_valid` during WAIT.
  - Required: `mem_ready` high only in cycle N+4; WAIT-cycle toggles ignored; exactly one response.
- Out of range:
  - Stimulus: store to `0x7FFF_FFFC`, then load `BASE + DEPTH*4`.
  - Required: both responses have `mem_error`=1 and `mem_rdata`=0; RAM word 0 and word `DEPTH-1` unchanged.
- Reset mid-operation, `WAIT_STATES`=3:
  - Stimulus: store `0x12345678` to `BASE`; assert `rst`=0 one cycle after acceptance; then load `BASE`.
  - Required: no ready pulse for the store; load returns the pre-store value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: tightly-coupled data RAM answering one load/store at a time
// with a programmable number of wait states and a one-cycle ready pulse.
module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE        = 32'h8000_0000
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [1:0]  IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    req_wstrb;
    logic [31:0]   ram [DEPTH];
    logic          accept, commit, in_range;
    logic [31:0]   c_addr, c_wdata, off;
    logic [3:0]    c_wstrb;
    logic [AW-1:0] idx;
    logic          unused;

    assign accept   = mem_valid && (state == IDLE || state == RESP);
    assign commit   = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd1);
    // A zero-wait request commits on its acceptance edge, before the latch holds it.
    assign c_addr   = accept ? mem_addr  : req_addr;
    assign c_wdata  = accept ? mem_wdata : req_wdata;
    assign c_wstrb  = accept ? mem_wstrb : req_wstrb;
    assign off      = c_addr - BASE;
    assign in_range = off < SPAN;
    assign idx      = off[AW+1:2];
    assign unused   = ^{mem_instr, off[1:0], off[31:AW+2]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
        end else begin
            mem_ready <= commit;
            mem_error <= commit && !in_range;
            if (commit)
                mem_rdata <= (in_range && c_wstrb == 4'd0) ? ram[idx] : 32'd0;
            state <= commit ? RESP : (accept || state == WAIT) ? WAIT : IDLE;
            cnt   <= accept ? 4'(WAIT_STATES) : (state == WAIT) ? cnt - 4'd1 : cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
        end
    end

    // RAM is deliberately not reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (rst && commit && in_range)
            for (int i = 0; i < 4; i++)
                if (c_wstrb[i])
                    ram[idx][8*i +: 8] <= c_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors on a zero-wait instance plus hand-written
// wait-state and mid-operation reset sequences on a three-wait instance.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, valid_b;
    logic [31:0] addr_a, addr_b, wdata_a, wdata_b, rdata_a, rdata_b;
    logic [3:0]  wstrb_a, wstrb_b;
    logic        ready_a, ready_b, error_a, error_b;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut_a (
        .rst(rst), .clk(clk), .mem_valid(valid_a), .mem_instr(1'b0),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wstrb(wstrb_a),
        .mem_ready(ready_a), .mem_rdata(rdata_a), .mem_error(error_a));

    dmem_responder #(.DEPTH(64), .WAIT_STATES(3)) dut_b (
        .rst(rst), .clk(clk), .mem_valid(valid_b), .mem_instr(1'b1),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wstrb(wstrb_b),
        .mem_ready(ready_b), .mem_rdata(rdata_b), .mem_error(error_b));

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        ready;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t v[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_b(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rdata, input logic exp_err, input string name);
        int n_resp = 0;
        valid_b = 1'b1; addr_b = a; wdata_b = d; wstrb_b = s;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("%s ready k=%0d", name, k), 32'(ready_b), 32'(k == 4));
            n_resp += int'(ready_b);
            if (k == 4) begin
                chk({name, " rdata"}, rdata_b, exp_rdata);
                chk({name, " error"}, 32'(error_b), 32'(exp_err));
            end
            // Toggle valid and scramble the request inputs while the request is outstanding.
            valid_b = (k <= 3) ? k[0] : 1'b0;
            addr_b  = 32'h8000_0040;
            wdata_b = 32'h0BAD_0BAD;
            wstrb_b = 4'hF;
        end
        chk({name, " responses"}, 32'(n_resp), 32'd1);
    endtask

    initial begin
        v[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000, 1'b0};
        v[1]  = '{1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        v[2]  = '{1'b1, 32'h8000_0010, 32'h0000_1100, 4'h2, 1'b1, 32'h0000_0000, 1'b0};
        v[3]  = '{1'b1, 32'h8000_0010, 32'h5500_0000, 4'h8, 1'b1, 32'h0000_0000, 1'b0};
        v[4]  = '{1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'h55AD_11EF, 1'b0};
        v[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 32'h55AD_11EF, 1'b0};
        v[6]  = '{1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF, 1'b1, 32'h0000_0000, 1'b0};
        v[7]  = '{1'b1, 32'h8000_00FC, 32'h2222_2222, 4'hF, 1'b1, 32'h0000_0000, 1'b0};
        v[8]  = '{1'b1, 32'h7FFF_FFFC, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h0000_0000, 1'b1};
        v[9]  = '{1'b1, 32'h8000_0100, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 1'b1};
        v[10] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 4'h0, 1'b1, 32'h1111_1111, 1'b0};
        v[11] = '{1'b1, 32'h8000_00FC, 32'h0000_0000, 4'h0, 1'b1, 32'h2222_2222, 1'b0};
        v[12] = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000, 1'b0};
        v[13] = '{1'b1, 32'h8000_0020, 32'h1234_5678, 4'h5, 1'b1, 32'h0000_0000, 1'b0};
        v[14] = '{1'b1, 32'h8000_0023, 32'h0000_0000, 4'h0, 1'b1, 32'hFF34_FF78, 1'b0};
        v[15] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 32'hFF34_FF78, 1'b0};
        v[16] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 1'b1};
        v[17] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 1'b0};

        rst = 1'b0;
        valid_a = 1'b0; addr_a = '0; wdata_a = '0; wstrb_a = '0;
        valid_b = 1'b0; addr_b = '0; wdata_b = '0; wstrb_b = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset ready_a", 32'(ready_a), 32'd0);
            chk("reset ready_b", 32'(ready_b), 32'd0);
            chk("reset error_a", 32'(error_a), 32'd0);
            chk("reset rdata_a", rdata_a, 32'd0);
            chk("reset rdata_b", rdata_b, 32'd0);
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle ready_a", 32'(ready_a), 32'd0);
            chk("idle ready_b", 32'(ready_b), 32'd0);
            chk("idle error_b", 32'(error_b), 32'd0);
            chk("idle rdata_a", rdata_a, 32'd0);
        end

        for (int i = 0; i < 18; i++) begin
            valid_a = v[i].valid; addr_a = v[i].addr; wdata_a = v[i].wdata; wstrb_a = v[i].wstrb;
            @(negedge clk);
            chk($sformatf("vec%0d ready", i), 32'(ready_a), 32'(v[i].ready));
            chk($sformatf("vec%0d rdata", i), rdata_a, v[i].rdata);
            chk($sformatf("vec%0d error", i), 32'(error_a), 32'(v[i].err));
        end
        valid_a = 1'b0;

        run_b(32'h8000_0010, 32'hC0FF_EE00, 4'hF, 32'h0000_0000, 1'b0, "ws store");
        run_b(32'h8000_0010, 32'h0000_0000, 4'h0, 32'hC0FF_EE00, 1'b0, "ws load");
        run_b(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0, "ws store base");
        run_b(32'h8000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0, "ws load base");
        run_b(32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1, "ws oor store");

        valid_b = 1'b1; addr_b = 32'h8000_0000; wdata_b = 32'h1234_5678; wstrb_b = 4'hF;
        @(negedge clk);
        valid_b = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset ready_b", 32'(ready_b), 32'd0);
        chk("midreset rdata_b", rdata_b, 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post reset ready_b", 32'(ready_b), 32'd0);
        end
        run_b(32'h8000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0, "load after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
